// File: rtl/fwd_hazard_pipe_pkg.sv
// Shared types and constants for the operand-forwarding / load-use hazard block.
// Holds the fwd-select width helper, reserved encodings and the EX control bundle.
package fwd_hazard_pipe_pkg;

  localparam int FWD_SEL_RF = 0;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic valid;
    logic we;
    logic compflg;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{valid: 1'b0, we: 1'b0, compflg: 1'b0};

  // Select encoding: 0 = register file, s+1 = bypass stage s.
  function automatic int fwd_sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Priority bypass match for one source operand: picks the youngest matching stage
// (lowest index) or the register-file value, and flags when that producer is not ready.
module fwd_operand_sel
  import fwd_hazard_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_STAGES = 3,
  parameter int SEL_W      = fwd_sel_w(NUM_STAGES)
) (
  input  logic [REG_ADDR_W-1:0]            i_rs,
  input  logic                             i_rs_used,
  input  logic [XLEN-1:0]                  i_rf_data,
  input  logic [NUM_STAGES-1:0]            i_byp_valid,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] i_byp_rd,
  input  logic [NUM_STAGES-1:0]            i_byp_ready,
  input  logic [NUM_STAGES*XLEN-1:0]       i_byp_data,
  output logic [SEL_W-1:0]                 o_sel,
  output logic [XLEN-1:0]                  o_data,
  output logic                             o_need_stall
);

  logic [NUM_STAGES-1:0] w_match;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_match
    assign w_match[s] = i_rs_used && i_byp_valid[s]
                     && (i_byp_rd[s*REG_ADDR_W +: REG_ADDR_W] == i_rs)
                     && (i_rs != REG_ADDR_W'(REG_ZERO));
  end

  // Walk oldest to youngest so the youngest match overwrites, including its
  // ready bit: an older ready copy must never mask a younger pending load.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_sel        = SEL_W'(FWD_SEL_RF);
    o_data       = i_rf_data;
    o_need_stall = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (w_match[s]) begin
        o_sel        = SEL_W'(s + 1);
        o_data       = i_byp_data[s*XLEN +: XLEN];
        o_need_stall = !i_byp_ready[s];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_pipe.sv
// Operand forwarding, load-use hazard detection and the ID/EX pipeline register.
// Optional FWD_STATS_EN adds saturating stall / forward event counters.
module fwd_hazard_pipe
  import fwd_hazard_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 3
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     flush,
  input  logic                                     ex_hold,
  input  logic                                     id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]            id_rs,
  input  logic [NUM_SRC-1:0]                       id_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]                  id_rf_data,
  input  logic [XLEN-1:0]                          id_imm,
  input  logic [REG_ADDR_W-1:0]                    id_rd,
  input  logic                                     id_we,
  input  logic                                     id_compflg,
  input  logic [NUM_STAGES-1:0]                    byp_valid,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0]         byp_rd,
  input  logic [NUM_STAGES-1:0]                    byp_ready,
  input  logic [NUM_STAGES*XLEN-1:0]               byp_data,
  output logic                                     id_stall,
  output logic                                     ex_valid,
  output logic [NUM_SRC*XLEN-1:0]                  ex_op,
  output logic [XLEN-1:0]                          ex_imm,
  output logic [REG_ADDR_W-1:0]                    ex_rd,
  output logic                                     ex_we,
  output logic                                     ex_compflg,
  output logic [NUM_SRC*$clog2(NUM_STAGES+1)-1:0]  ex_fwd_sel
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                              stat_stall_cnt,
  output logic [31:0]                              stat_fwd_cnt
`endif
);

  localparam int SEL_W = fwd_sel_w(NUM_STAGES);

  logic [NUM_SRC*SEL_W-1:0] w_sel;
  logic [NUM_SRC*XLEN-1:0]  w_op;
  logic [NUM_SRC-1:0]       w_need_stall;
  logic                     w_hazard;
  logic                     w_load;
  logic                     w_bubble;

  ex_ctrl_t                 r_ex_ctrl;
  logic [NUM_SRC*XLEN-1:0]  r_ex_op;
  logic [XLEN-1:0]          r_ex_imm;
  logic [REG_ADDR_W-1:0]    r_ex_rd;
  logic [NUM_SRC*SEL_W-1:0] r_ex_fwd_sel;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_operand_sel #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W),
      .NUM_STAGES (NUM_STAGES),
      .SEL_W      (SEL_W)
    ) u_sel (
      .i_rs         (id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
      .i_rs_used    (id_rs_used[k]),
      .i_rf_data    (id_rf_data[k*XLEN +: XLEN]),
      .i_byp_valid  (byp_valid),
      .i_byp_rd     (byp_rd),
      .i_byp_ready  (byp_ready),
      .i_byp_data   (byp_data),
      .o_sel        (w_sel[k*SEL_W +: SEL_W]),
      .o_data       (w_op[k*XLEN +: XLEN]),
      .o_need_stall (w_need_stall[k])
    );
  end

  assign w_hazard = id_valid && (|w_need_stall);
  assign id_stall = (w_hazard && !flush) || ex_hold;

  // Flush beats hold; hold beats a hazard bubble; an invalid decode loads a bubble.
  assign w_load   = !flush && !ex_hold && !w_hazard && id_valid;
  assign w_bubble = flush || (!ex_hold && !w_load);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n || w_bubble) begin
      r_ex_ctrl    <= EX_CTRL_BUBBLE;
      r_ex_op      <= '0;
      r_ex_imm     <= '0;
      r_ex_rd      <= '0;
      r_ex_fwd_sel <= '0;
    end else if (w_load) begin
      r_ex_ctrl    <= '{valid: 1'b1, we: id_we, compflg: id_compflg};
      r_ex_op      <= w_op;
      r_ex_imm     <= id_imm;
      r_ex_rd      <= id_rd;
      r_ex_fwd_sel <= w_sel;
    end
  end

  assign ex_valid   = r_ex_ctrl.valid;
  assign ex_we      = r_ex_ctrl.we;
  assign ex_compflg = r_ex_ctrl.compflg;
  assign ex_op      = r_ex_op;
  assign ex_imm     = r_ex_imm;
  assign ex_rd      = r_ex_rd;
  assign ex_fwd_sel = r_ex_fwd_sel;

`ifdef FWD_STATS_EN
  localparam int CNT_W = $clog2(NUM_SRC + 1);

  logic [CNT_W-1:0] w_fwd_num;
  logic [32:0]      w_fwd_sum;
  logic             w_stall_bubble;
  logic [31:0]      r_stall_cnt;
  logic [31:0]      r_fwd_cnt;

  always_comb begin
    w_fwd_num = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_sel[k*SEL_W +: SEL_W] != SEL_W'(FWD_SEL_RF)) begin
        w_fwd_num = w_fwd_num + CNT_W'(1);
      end
    end
  end

  assign w_fwd_sum      = {1'b0, r_fwd_cnt} + 33'(w_fwd_num);
  assign w_stall_bubble = w_hazard && !flush && !ex_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall_bubble && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_load) begin
        r_fwd_cnt <= w_fwd_sum[32] ? '1 : w_fwd_sum[31:0];
      end
    end
  end

  assign stat_stall_cnt = r_stall_cnt;
  assign stat_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_pipe.sv
// Self-checking bench for fwd_hazard_pipe: directed scenarios plus randomized
// traffic against a search-based reference model of forwarding and the EX register.
module tb_fwd_hazard_pipe;

  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int NS    = 2;
  localparam int NST   = 3;
  localparam int SEL_W = $clog2(NST + 1);

  logic                clk = 1'b0;
  logic                reset_n;
  logic                flush;
  logic                ex_hold;
  logic                id_valid;
  logic [NS*RW-1:0]    id_rs;
  logic [NS-1:0]       id_rs_used;
  logic [NS*XLEN-1:0]  id_rf_data;
  logic [XLEN-1:0]     id_imm;
  logic [RW-1:0]       id_rd;
  logic                id_we;
  logic                id_compflg;
  logic [NST-1:0]      byp_valid;
  logic [NST*RW-1:0]   byp_rd;
  logic [NST-1:0]      byp_ready;
  logic [NST*XLEN-1:0] byp_data;
  logic                id_stall;
  logic                ex_valid;
  logic [NS*XLEN-1:0]  ex_op;
  logic [XLEN-1:0]     ex_imm;
  logic [RW-1:0]       ex_rd;
  logic                ex_we;
  logic                ex_compflg;
  logic [NS*SEL_W-1:0] ex_fwd_sel;
`ifdef FWD_STATS_EN
  logic [31:0]         stat_stall_cnt;
  logic [31:0]         stat_fwd_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fwd_hazard_pipe #(
    .XLEN(XLEN), .REG_ADDR_W(RW), .NUM_SRC(NS), .NUM_STAGES(NST)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .ex_hold    (ex_hold),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rf_data (id_rf_data),
    .id_imm     (id_imm),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_compflg (id_compflg),
    .byp_valid  (byp_valid),
    .byp_rd     (byp_rd),
    .byp_ready  (byp_ready),
    .byp_data   (byp_data),
    .id_stall   (id_stall),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_imm     (ex_imm),
    .ex_rd      (ex_rd),
    .ex_we      (ex_we),
    .ex_compflg (ex_compflg),
    .ex_fwd_sel (ex_fwd_sel)
`ifdef FWD_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_fwd_cnt   (stat_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; ex_hold = 1'b0; id_valid = 1'b0;
    id_rs = '0; id_rs_used = '0; id_rf_data = '0; id_imm = '0;
    id_rd = '0; id_we = 1'b0; id_compflg = 1'b0;
    byp_valid = '0; byp_rd = '0; byp_ready = '0; byp_data = '0;
  endtask

  task automatic set_stage(input int s, input logic v, input logic [RW-1:0] rd,
                           input logic rdy, input logic [XLEN-1:0] d);
    byp_valid[s]             = v;
    byp_rd[s*RW +: RW]       = rd;
    byp_ready[s]             = rdy;
    byp_data[s*XLEN +: XLEN] = d;
  endtask

  task automatic set_src(input int k, input logic used, input logic [RW-1:0] rs,
                         input logic [XLEN-1:0] rf);
    id_rs_used[k]              = used;
    id_rs[k*RW +: RW]          = rs;
    id_rf_data[k*XLEN +: XLEN] = rf;
  endtask

  task automatic set_instr(input logic [RW-1:0] rd, input logic we,
                           input logic [XLEN-1:0] imm, input logic cf);
    id_valid = 1'b1; id_rd = rd; id_we = we; id_imm = imm; id_compflg = cf;
  endtask

  // Reference: search each operand's bypass list youngest-first, stopping at the first hit.
  task automatic model_fwd(output logic [NS*XLEN-1:0] op, output logic [NS*SEL_W-1:0] sel,
                           output logic hz);
    logic [RW-1:0] rs;
    hz  = 1'b0;
    op  = id_rf_data;
    sel = '0;
    for (int k = 0; k < NS; k++) begin
      rs = id_rs[k*RW +: RW];
      if (id_rs_used[k] && rs != 0) begin
        for (int s = 0; s < NST; s++) begin
          if (byp_valid[s] && byp_rd[s*RW +: RW] == rs) begin
            op[k*XLEN +: XLEN]   = byp_data[s*XLEN +: XLEN];
            sel[k*SEL_W +: SEL_W] = SEL_W'(s + 1);
            if (!byp_ready[s]) hz = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    tick(); tick();
    tests_run++;
    if ({ex_valid, ex_we, ex_compflg, ex_rd, ex_imm, ex_op, ex_fwd_sel} !== '0) begin
      tests_failed++;
      $display("FAIL reset_initial: ex fields=%h required 0",
               {ex_valid, ex_we, ex_compflg, ex_rd, ex_imm, ex_op, ex_fwd_sel});
    end
    reset_n = 1'b1;
    set_instr(5'd3, 1'b1, 32'h77, 1'b1);
    set_src(0, 1'b1, 5'd2, 32'hCAFE);
    tick();
    tests_run++;
    if (ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_preload_valid: ex_valid=%b required 1", ex_valid);
    end
    // Reset asserted while a load-use hazard is present.
    set_stage(0, 1'b1, 5'd7, 1'b0, 32'h0);
    set_src(1, 1'b1, 5'd7, 32'h0);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_stall_id_stall: id_stall=%b required 1", id_stall);
    end
    tick();
    tests_run++;
    if ({ex_valid, ex_we, ex_compflg, ex_rd, ex_imm, ex_op, ex_fwd_sel} !== '0) begin
      tests_failed++;
      $display("FAIL reset_clears_ex: ex fields=%h required 0",
               {ex_valid, ex_we, ex_compflg, ex_rd, ex_imm, ex_op, ex_fwd_sel});
    end
    reset_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    set_stage(0, 1'b1, 5'd5, 1'b1, 32'h1234);
    set_stage(1, 1'b1, 5'd5, 1'b1, 32'hAAAA);
    set_instr(5'd6, 1'b1, 32'h0, 1'b0);
    set_src(0, 1'b1, 5'd5, 32'hDEAD);
    set_src(1, 1'b0, 5'd5, 32'hBEEF);
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_id_stall: id_stall=%b required 0", id_stall);
    end
    tick();
    tests_run++;
    if (ex_op[0 +: XLEN] !== 32'h1234 || ex_fwd_sel[0 +: SEL_W] !== 2'd1 || ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL fwd_op0: op=%h sel=%0d valid=%b required op=1234 sel=1 valid=1",
               ex_op[0 +: XLEN], ex_fwd_sel[0 +: SEL_W], ex_valid);
    end
    tests_run++;
    if (ex_op[XLEN +: XLEN] !== 32'hBEEF || ex_fwd_sel[SEL_W +: SEL_W] !== 2'd0) begin
      tests_failed++;
      $display("FAIL fwd_unused_op1: op=%h sel=%0d required op=beef sel=0",
               ex_op[XLEN +: XLEN], ex_fwd_sel[SEL_W +: SEL_W]);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    set_stage(0, 1'b1, 5'd7, 1'b0, 32'h0);
    set_instr(5'd9, 1'b1, 32'h4, 1'b0);
    set_src(1, 1'b1, 5'd7, 32'h1111);
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL loaduse_stall: id_stall=%b required 1", id_stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL loaduse_bubble: ex_valid=%b required 0", ex_valid);
    end
    // Older ready copy must not hide the younger pending load.
    set_stage(1, 1'b1, 5'd7, 1'b1, 32'h99);
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL loaduse_younger_unready: id_stall=%b required 1", id_stall);
    end
    tick();
    set_stage(0, 1'b0, 5'd0, 1'b0, 32'h0);
    set_stage(1, 1'b1, 5'd7, 1'b1, 32'h55);
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL loaduse_release: id_stall=%b required 0", id_stall);
    end
    tick();
    tests_run++;
    if (ex_op[XLEN +: XLEN] !== 32'h55 || ex_fwd_sel[SEL_W +: SEL_W] !== 2'd2 || ex_valid !== 1'b1
        || ex_rd !== 5'd9) begin
      tests_failed++;
      $display("FAIL loaduse_fwd: op1=%h sel1=%0d valid=%b rd=%0d required op1=55 sel1=2 valid=1 rd=9",
               ex_op[XLEN +: XLEN], ex_fwd_sel[SEL_W +: SEL_W], ex_valid, ex_rd);
    end
    clear_inputs();
  endtask

  task automatic test_x0();
    clear_inputs();
    set_stage(0, 1'b1, 5'd0, 1'b1, 32'hFFFF);
    set_instr(5'd1, 1'b1, 32'h0, 1'b0);
    set_src(0, 1'b1, 5'd0, 32'h0);
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_stall: id_stall=%b required 0", id_stall);
    end
    tick();
    tests_run++;
    if (ex_op[0 +: XLEN] !== 32'h0 || ex_fwd_sel[0 +: SEL_W] !== 2'd0) begin
      tests_failed++;
      $display("FAIL x0_op: op0=%h sel0=%0d required op0=0 sel0=0",
               ex_op[0 +: XLEN], ex_fwd_sel[0 +: SEL_W]);
    end
    set_stage(0, 1'b1, 5'd0, 1'b0, 32'hFFFF);
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_unready_nostall: id_stall=%b required 0", id_stall);
    end
    clear_inputs();
  endtask

  task automatic test_flush_hazard();
    clear_inputs();
    set_instr(5'd4, 1'b1, 32'hABC, 1'b1);
    tick();
    set_stage(0, 1'b1, 5'd7, 1'b0, 32'h0);
    set_src(1, 1'b1, 5'd7, 32'h0);
    flush = 1'b1;
    #1;
    tests_run++;
    if (id_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: id_stall=%b required 0", id_stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_rd !== '0 || ex_imm !== '0 || ex_compflg !== 1'b0 || ex_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_bubble: valid=%b rd=%0d imm=%h cf=%b we=%b required all 0",
               ex_valid, ex_rd, ex_imm, ex_compflg, ex_we);
    end
    clear_inputs();
    set_instr(5'd4, 1'b1, 32'hABC, 1'b1);
    tick();
    flush = 1'b1; ex_hold = 1'b1;
    #1;
    tests_run++;
    if (id_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_hold_stall: id_stall=%b required 1", id_stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_imm !== '0) begin
      tests_failed++;
      $display("FAIL flush_beats_hold: valid=%b imm=%h required 0 0", ex_valid, ex_imm);
    end
    clear_inputs();
  endtask

  task automatic test_ex_hold();
    clear_inputs();
    set_instr(5'd10, 1'b1, 32'h100, 1'b0);
    set_src(0, 1'b1, 5'd1, 32'h11);
    tick();
    ex_hold = 1'b1;
    set_instr(5'd12, 1'b0, 32'h200, 1'b1);
    set_src(0, 1'b1, 5'd1, 32'h22);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (id_stall !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_stall[%0d]: id_stall=%b required 1", i, id_stall);
      end
      tick();
      tests_run++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || ex_imm !== 32'h100 || ex_op[0 +: XLEN] !== 32'h11
          || ex_we !== 1'b1 || ex_compflg !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_keep[%0d]: valid=%b rd=%0d imm=%h op0=%h we=%b cf=%b required 1 10 100 11 1 0",
                 i, ex_valid, ex_rd, ex_imm, ex_op[0 +: XLEN], ex_we, ex_compflg);
      end
    end
    ex_hold = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || ex_imm !== 32'h200 || ex_op[0 +: XLEN] !== 32'h22
        || ex_we !== 1'b0 || ex_compflg !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_release: valid=%b rd=%0d imm=%h op0=%h we=%b cf=%b required 1 12 200 22 0 1",
               ex_valid, ex_rd, ex_imm, ex_op[0 +: XLEN], ex_we, ex_compflg);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NS*XLEN-1:0]  m_op;
    logic [NS*SEL_W-1:0] m_sel;
    logic                m_hz;
    logic                e_stall;
    logic                e_valid, e_we, e_cf;
    logic [RW-1:0]       e_rd;
    logic [XLEN-1:0]     e_imm;
    logic [NS*XLEN-1:0]  e_op;
    logic [NS*SEL_W-1:0] e_sel;
    e_valid = 1'b0; e_we = 1'b0; e_cf = 1'b0; e_rd = '0; e_imm = '0; e_op = '0; e_sel = '0;
    for (int i = 0; i < 400; i++) begin
      reset_n    = (i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      ex_hold    = ($urandom_range(0, 7) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_we      = $urandom_range(0, 1);
      id_compflg = $urandom_range(0, 1);
      id_rd      = RW'($urandom_range(0, 31));
      id_imm     = $urandom;
      id_rf_data = {$urandom, $urandom};
      byp_data   = {$urandom, $urandom, $urandom};
      for (int k = 0; k < NS; k++) begin
        id_rs_used[k]     = $urandom_range(0, 1);
        id_rs[k*RW +: RW] = RW'($urandom_range(0, 3));
      end
      for (int s = 0; s < NST; s++) begin
        byp_valid[s]       = $urandom_range(0, 1);
        byp_rd[s*RW +: RW] = RW'($urandom_range(0, 3));
        byp_ready[s]       = ($urandom_range(0, 3) != 0);
      end
      #1;
      model_fwd(m_op, m_sel, m_hz);
      e_stall = (id_valid && !flush && m_hz) || ex_hold;
      tests_run++;
      if (id_stall !== e_stall) begin
        tests_failed++;
        $display("FAIL rand_stall[%0d]: id_stall=%b required %b", i, id_stall, e_stall);
      end
      if (!reset_n || flush || (!ex_hold && (!id_valid || m_hz))) begin
        e_valid = 1'b0; e_we = 1'b0; e_cf = 1'b0; e_rd = '0; e_imm = '0; e_op = '0; e_sel = '0;
      end else if (!ex_hold) begin
        e_valid = 1'b1; e_we = id_we; e_cf = id_compflg; e_rd = id_rd; e_imm = id_imm;
        e_op = m_op; e_sel = m_sel;
      end
      tick();
      tests_run++;
      if ({ex_valid, ex_we, ex_compflg, ex_rd, ex_imm, ex_op, ex_fwd_sel}
          !== {e_valid, e_we, e_cf, e_rd, e_imm, e_op, e_sel}) begin
        tests_failed++;
        $display("FAIL rand_ex[%0d]: got %h required %h", i,
                 {ex_valid, ex_we, ex_compflg, ex_rd, ex_imm, ex_op, ex_fwd_sel},
                 {e_valid, e_we, e_cf, e_rd, e_imm, e_op, e_sel});
      end
    end
    reset_n = 1'b1;
    clear_inputs();
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    clear_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tests_run++;
    if (stat_stall_cnt !== 32'd0 || stat_fwd_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: stall=%0d fwd=%0d required 0 0", stat_stall_cnt, stat_fwd_cnt);
    end
    set_stage(0, 1'b1, 5'd7, 1'b0, 32'h0);
    set_instr(5'd8, 1'b1, 32'h0, 1'b0);
    set_src(1, 1'b1, 5'd7, 32'h0);
    tick(); tick();
    set_stage(0, 1'b1, 5'd7, 1'b1, 32'h70);
    set_src(0, 1'b1, 5'd7, 32'h0);
    tick();
    set_src(1, 1'b0, 5'd7, 32'h0);
    tick();
    id_valid = 1'b0;
    tick();
    tests_run++;
    if (stat_stall_cnt !== 32'd2 || stat_fwd_cnt !== 32'd3) begin
      tests_failed++;
      $display("FAIL stats_counts: stall=%0d fwd=%0d required 2 3", stat_stall_cnt, stat_fwd_cnt);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_ex_forward();
    test_load_use();
    test_x0();
    test_flush_hazard();
    test_ex_hold();
    test_random();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
